// File: rtl/signed_seg_scan_ctrl.sv
// signed_seg_scan_ctrl
// Drives a two-digit signed 7-segment display (sign digit + magnitude digit)
// from a 4-bit two's-complement value over one shared active-low segment bus.
// New values are accepted via valid/ready into a pending register and are
// committed to the displayed register only at the frame boundary, so a frame
// never tears. Dead-time blanking precedes each digit slot to avoid ghosting.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_val       two's-complement value to display (-8..+7)
//   in_valid     in_val is valid
//   in_ready     pending register empty; transfer when in_valid & in_ready
//   seg          shared segment bus {a..g}, a is MSB, active-low
//   dig_n        active-low digit enables; [1] sign digit, [0] magnitude digit
//   frame_tick   one-cycle pulse in the first cycle of each frame
//   bright       dimming level, present only when SEG_SCAN_DIM_EN is defined
//
// Optional feature: define SEG_SCAN_DIM_EN to add the bright port and
// PWM-style digit-enable dimming (DIV must then be a multiple of 8).

module signed_seg_scan_ctrl #(
   parameter int unsigned DIV       = 16,
   parameter int unsigned BLANK_CYC = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] in_val,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [6:0] seg,
   output logic [1:0] dig_n,
   output logic       frame_tick
`ifdef SEG_SCAN_DIM_EN
   ,
   input  logic [2:0] bright
`endif
);

   localparam int unsigned MAX_LEN = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b1111110;
   localparam logic [1:0] DIG_OFF   = 2'b11;
   localparam logic [1:0] DIG_SIGN  = 2'b10;
   localparam logic [1:0] DIG_MAG   = 2'b01;

   typedef enum logic [1:0] {
      BLANK_S   = 2'd0,
      SHOW_SIGN = 2'd1,
      BLANK_M   = 2'd2,
      SHOW_MAG  = 2'd3
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [3:0]       disp, disp_d;
   logic [3:0]       pending, pending_d;
   logic             pending_full, pending_full_d;
   logic             in_ready_d;
   logic [6:0]       seg_d;
   logic [1:0]       dig_n_d;
   logic             frame_tick_d;

   logic [CNT_W-1:0] slot_last_cnt;
   logic             slot_last;
   logic             accept;
   logic [3:0]       mag;
   logic [6:0]       mag_seg;

`ifdef SEG_SCAN_DIM_EN
   logic [2:0]       bright_q, bright_d;
   logic [CNT_W-1:0] dim_thresh;

   // Number of enabled cycles per show slot for the frame's brightness level.
   assign dim_thresh = CNT_W'((32'(bright_q) + 32'd1) * (DIV / 8));
`endif

   // Last cycle of the current slot: show slots last DIV, blank slots BLANK_CYC.
   assign slot_last_cnt = ((state == SHOW_SIGN) || (state == SHOW_MAG))
                          ? CNT_W'(DIV - 1) : CNT_W'(BLANK_CYC - 1);
   assign slot_last     = (cnt == slot_last_cnt);
   assign accept        = in_valid & in_ready;

   // Absolute value in 4 bits; -8 wraps to 4'b1000, which reads as 8.
   assign mag = disp[3] ? (~disp + 4'd1) : disp;

   // Magnitude digit decode, active-low {a..g}.
   always_comb begin
      mag_seg = SEG_BLANK;
      case (mag)
         4'd0:    mag_seg = 7'b0000001;
         4'd1:    mag_seg = 7'b1001111;
         4'd2:    mag_seg = 7'b0010010;
         4'd3:    mag_seg = 7'b0000110;
         4'd4:    mag_seg = 7'b1001100;
         4'd5:    mag_seg = 7'b0100100;
         4'd6:    mag_seg = 7'b0100000;
         4'd7:    mag_seg = 7'b0001111;
         4'd8:    mag_seg = 7'b0000000;
         default: mag_seg = SEG_BLANK;
      endcase
   end

   // Next-state, handshake/commit and registered-output logic.
   always_comb begin
      state_d        = state;
      cnt_d          = cnt + CNT_W'(1);
      disp_d         = disp;
      pending_d      = pending;
      pending_full_d = pending_full;
      seg_d          = seg;
      dig_n_d        = dig_n;
      frame_tick_d   = 1'b0;
`ifdef SEG_SCAN_DIM_EN
      bright_d       = bright_q;
`endif

      // Accept and commit are mutually exclusive: accept needs pending empty,
      // commit needs it full.
      if (accept) begin
         pending_d      = in_val;
         pending_full_d = 1'b1;
      end

      if (slot_last) begin
         cnt_d = '0;
         case (state)
            BLANK_S: begin
               state_d = SHOW_SIGN;
               seg_d   = disp[3] ? SEG_MINUS : SEG_BLANK;
               dig_n_d = DIG_SIGN;
            end
            SHOW_SIGN: begin
               state_d = BLANK_M;
               seg_d   = SEG_BLANK;
               dig_n_d = DIG_OFF;
            end
            BLANK_M: begin
               state_d = SHOW_MAG;
               seg_d   = mag_seg;
               dig_n_d = DIG_MAG;
            end
            SHOW_MAG: begin
               // Frame boundary: commit pending, pulse tick, latch brightness.
               state_d      = BLANK_S;
               seg_d        = SEG_BLANK;
               dig_n_d      = DIG_OFF;
               frame_tick_d = 1'b1;
               if (pending_full) begin
                  disp_d         = pending;
                  pending_full_d = 1'b0;
               end
`ifdef SEG_SCAN_DIM_EN
               bright_d = bright;
`endif
            end
            default: begin
               state_d = BLANK_S;
               seg_d   = SEG_BLANK;
               dig_n_d = DIG_OFF;
            end
         endcase
      end

`ifdef SEG_SCAN_DIM_EN
      // Dimming only ever switches the enable off; once past the threshold it
      // stays off until the slot ends.
      if (((state_d == SHOW_SIGN) || (state_d == SHOW_MAG)) && (cnt_d >= dim_thresh)) begin
         dig_n_d = DIG_OFF;
      end
`endif

      in_ready_d = ~pending_full_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= BLANK_S;
         cnt          <= '0;
         disp         <= 4'b0000;
         pending      <= 4'b0000;
         pending_full <= 1'b0;
         in_ready     <= 1'b1;
         seg          <= SEG_BLANK;
         dig_n        <= DIG_OFF;
         frame_tick   <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
         // Full brightness until the first frame boundary samples bright.
         bright_q     <= 3'd7;
`endif
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         disp         <= disp_d;
         pending      <= pending_d;
         pending_full <= pending_full_d;
         in_ready     <= in_ready_d;
         seg          <= seg_d;
         dig_n        <= dig_n_d;
         frame_tick   <= frame_tick_d;
`ifdef SEG_SCAN_DIM_EN
         bright_q     <= bright_d;
`endif
      end
   end

endmodule

// File: doc/signed_seg_scan_ctrl.md
Name: signed_seg_scan_ctrl

Overview:
- Time-multiplexes one shared active-low 7-segment bus across a two-digit signed display: a sign digit and a magnitude digit.
- Shows a 4-bit two's-complement value in the range -8..+7.
- Accepts new values through a valid/ready handshake and commits them only at frame boundaries, so a frame never tears.
- Inserts dead-time blanking between digit slots to prevent ghosting; sits between datapath result registers and the board display pins.

Parameters:
- DIV, 16: clock cycles per digit show slot; minimum 2. Must be a multiple of 8 when DIM_EN is defined.
- BLANK_CYC, 2: dead-time cycles before each show slot; minimum 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_val  input  4  two's-complement value to display
- in_valid  input  1  in_val is valid
- in_ready  output  1  pending register is empty; a transfer occurs when in_valid & in_ready
- seg  output  7  shared segment bus {a,b,c,d,e,f,g}, a is MSB, active-low
- dig_n  output  2  digit enables, active-low; [1] is the sign digit, [0] the magnitude digit
- frame_tick  output  1  one-cycle pulse at each frame boundary
- bright  input  3  dimming level (present only with DIM_EN)

Behaviour:
- Clock and reset: single clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset state:
  - state = BLANK_S, slot counter cnt = 0.
  - Displayed register disp = 4'b0000; pending register empty.
  - seg = 7'b1111111, dig_n = 2'b11, in_ready = 1, frame_tick = 0.
  - Reset asserted mid-frame aborts immediately to these values; any pending value is discarded.
- State machine (cyclic order): BLANK_S (BLANK_CYC cycles) -> SHOW_SIGN (DIV cycles) -> BLANK_M (BLANK_CYC cycles) -> SHOW_MAG (DIV cycles) -> BLANK_S.
  - Frame length = 2*(DIV+BLANK_CYC) cycles.
  - cnt counts 0..len-1 within each state and clears on every transition.
- Registered outputs: seg and dig_n are flops loaded on the edge that enters a state and held for the whole state.
  - BLANK_S and BLANK_M: seg = 1111111, dig_n = 11.
  - SHOW_SIGN: dig_n = 10; seg = 1111110 (minus) if disp[3] = 1, else 1111111 (blank).
  - SHOW_MAG: dig_n = 01; seg shows the magnitude digit of disp.
- Magnitude: |disp| computed in 4 bits; -8 yields 8.
- Magnitude patterns:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000
- Handshake:
  - in_ready = !pending_full, registered.
  - An accepted value is written into pending; no bypass path into disp.
- Commit:
  - On the edge leaving SHOW_MAG, if pending_full then disp <= pending and pending clears.
  - frame_tick is high during the first BLANK_S cycle of every frame, whether or not a commit occurred.
- Simultaneous events:
  - Accept on the commit edge with pending empty: value lands in pending and displays from the following frame.
  - Accept is impossible while pending is full, because in_ready is low.
  - Pending always holds the newest accepted value.
- Timing:
  - in_valid may be held; in_val must stay stable while in_valid & !in_ready.
  - Worst-case latency from acceptance to display = one frame + BLANK_CYC + 1 cycles.

Optional Feature:
- Macro: SEG_SCAN_DIM_EN.
- Defined:
  - Port bright[2:0] exists.
  - Within SHOW_SIGN and SHOW_MAG, dig_n is driven to its active value only while cnt < (bright+1)*(DIV/8); for the rest of the slot dig_n = 11.
  - seg is unaffected.
  - bright is sampled at BLANK_S entry and held for the whole frame.
- Not defined: the port is absent, and the digit enable is active for the full show slot.

Test Plan (DIV=4, BLANK_CYC=1, frame = 10 cycles):
- Reset release, no input -> frame_tick every 10 cycles; sign slot seg = 1111111; magnitude slot seg = 0000001 with dig_n = 01 for 4 cycles; dig_n = 11 during blanking.
- Accept 4'b1101 (-3) mid-frame -> in_ready low next cycle; after the next frame boundary, sign slot seg = 1111110 with dig_n = 10, magnitude seg = 0000110; in_ready returns high.
- Accept 4'b1000 -> minus sign, magnitude seg = 0000000. Accept 4'b0111 -> blank sign, magnitude seg = 0001111.
- in_valid asserted on the commit edge with pending empty, value 4'b0010 -> no change in current frame; next frame magnitude seg = 0010010.
- Reset pulsed during SHOW_MAG with pending full -> seg = 1111111, dig_n = 11 immediately; disp = 0; in_ready = 1; old pending never displayed.
- SEG_SCAN_DIM_EN with DIV=8, bright = 3 -> dig_n active for 4 of 8 show cycles. With bright = 7 -> active for all 8.
